// File: rtl/logic_unit_arbiter.sv
// rtl/logic_unit_arbiter.sv - two-port round-robin arbiter in front of a shared logical-operation unit
//
// Purpose:
//   Two requesters share one combinational logic unit (AND / OR / XOR / ANDCM).
//   Port 0 is the execute stage, port 1 the auxiliary/microcode port. A
//   round-robin grant picks one request per cycle. The result of the accepted
//   request is registered into a single response slot, tagged with the
//   requester ID. The response slot can be back-pressured.
//
// Ports:
//   clk, rst                     clock; synchronous active-high reset
//   req0_valid / req0_ready      port 0 handshake
//   req0_op                      00 AND, 01 OR, 10 XOR, 11 ANDCM (a & ~b)
//   req0_a, req0_b               port 0 operands (bit 0 = MSB)
//   req1_*                       same as port 0, for port 1
//   rsp_valid / rsp_ready        response handshake
//   rsp_id                       requester that issued the held result
//   rsp_data                     registered result
//   cnt0, cnt1                   accepted-operation counters (wrap)

module logic_unit_arbiter #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [1:0]           req0_op,
  input  logic [0:WIDTH-1]     req0_a,
  input  logic [0:WIDTH-1]     req0_b,

  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [1:0]           req1_op,
  input  logic [0:WIDTH-1]     req1_a,
  input  logic [0:WIDTH-1]     req1_b,

  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [0:WIDTH-1]     rsp_data,

  output logic [CNT_WIDTH-1:0] cnt0,
  output logic [CNT_WIDTH-1:0] cnt1
);

  localparam logic [1:0] OP_AND   = 2'b00;
  localparam logic [1:0] OP_OR    = 2'b01;
  localparam logic [1:0] OP_XOR   = 2'b10;

  // Response slot occupancy. rsp_valid is a direct decode of the state flop.
  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t state;
  logic   last_grant;

  logic   grant0;
  logic   grant1;
  logic   slot_free;
  logic   accept0;
  logic   accept1;
  logic   accept_any;

  logic [1:0]       sel_op;
  logic [0:WIDTH-1] sel_a;
  logic [0:WIDTH-1] sel_b;
  logic [0:WIDTH-1] lu_result;

  // Shared logic unit. All four encodings are legal; ANDCM takes the last arm.
  function automatic logic [0:WIDTH-1] lu_eval(
    input logic [1:0]       op,
    input logic [0:WIDTH-1] a,
    input logic [0:WIDTH-1] b
  );
    logic [0:WIDTH-1] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = a & ~b;
    endcase
    return r;
  endfunction

  assign rsp_valid = (state == S_FULL);

  // Round-robin: a lone requester always wins; on contention the port that
  // did not win last time is preferred. last_grant only moves on accept, so a
  // stalled grant does not flip priority.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      grant0 = (last_grant == 1'b1);
      grant1 = (last_grant == 1'b0);
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  // The slot can take a new result if it is empty or being drained this cycle.
  assign slot_free = !rsp_valid || rsp_ready;

  // Readies are gated by rst so nothing is handshaken during reset.
  assign req0_ready = !rst && grant0 && slot_free;
  assign req1_ready = !rst && grant1 && slot_free;

  assign accept0    = req0_valid && req0_ready;
  assign accept1    = req1_valid && req1_ready;
  assign accept_any = accept0 || accept1;

  // Operand mux in front of the single logic unit. Operands only reach the
  // outputs through rsp_data, never combinationally.
  always_comb begin
    sel_op = req0_op;
    sel_a  = req0_a;
    sel_b  = req0_b;
    if (accept1) begin
      sel_op = req1_op;
      sel_a  = req1_a;
      sel_b  = req1_b;
    end
  end

  assign lu_result = lu_eval(sel_op, sel_a, sel_b);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_EMPTY;
      rsp_data   <= '0;
      rsp_id     <= 1'b0;
      last_grant <= 1'b1;
      cnt0       <= '0;
      cnt1       <= '0;
    end else begin
      case (state)
        S_EMPTY: begin
          if (accept_any) begin
            state <= S_FULL;
          end
        end
        S_FULL: begin
          // Drain and accept in the same edge keeps the slot full; the new
          // result simply replaces the old one.
          if (!accept_any && rsp_ready) begin
            state <= S_EMPTY;
          end
        end
        default: state <= S_EMPTY;
      endcase

      if (accept_any) begin
        rsp_data   <= lu_result;
        rsp_id     <= accept1;
        last_grant <= accept1;
      end

      // Counters wrap naturally at 2^CNT_WIDTH.
      if (accept0) begin
        cnt0 <= cnt0 + 1'b1;
      end
      if (accept1) begin
        cnt1 <= cnt1 + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb/tb_logic_unit_arbiter.sv - self-checking bench for logic_unit_arbiter

module tb_logic_unit_arbiter;

  localparam int WIDTH     = 32;
  localparam int CNT_WIDTH = 4;
  localparam int CNT_MOD   = 16;

  logic                 clk;
  logic                 rst;
  logic                 req0_valid;
  logic                 req0_ready;
  logic [1:0]           req0_op;
  logic [WIDTH-1:0]     req0_a;
  logic [WIDTH-1:0]     req0_b;
  logic                 req1_valid;
  logic                 req1_ready;
  logic [1:0]           req1_op;
  logic [WIDTH-1:0]     req1_a;
  logic [WIDTH-1:0]     req1_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic                 rsp_id;
  logic [WIDTH-1:0]     rsp_data;
  logic [CNT_WIDTH-1:0] cnt0;
  logic [CNT_WIDTH-1:0] cnt1;

  int checks = 0;
  int errors = 0;

  // Reference model: the response slot contents, who won last, and counts.
  bit          m_valid;
  bit          m_id;
  bit [31:0]   m_data;
  int          m_last;
  int          m_cnt0;
  int          m_cnt1;
  int          m_win;

  logic_unit_arbiter #(
    .WIDTH     (WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit [31:0] ref_op(input bit [1:0] op, input bit [31:0] a, input bit [31:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return a & ~b;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0;
    m_id    = 0;
    m_data  = 0;
    m_last  = 1;
    m_cnt0  = 0;
    m_cnt1  = 0;
  endtask

  // Called right after a falling edge with inputs already driven. Checks the
  // readies, advances the model across the rising edge, then checks outputs
  // at the next falling edge.
  task automatic cycle();
    int w;
    #1;
    w = -1;
    if (!rst && (!m_valid || rsp_ready)) begin
      if (req0_valid && req1_valid) w = (m_last == 0) ? 1 : 0;
      else if (req0_valid)          w = 0;
      else if (req1_valid)          w = 1;
    end
    chk("req0_ready", req0_ready, (w == 0));
    chk("req1_ready", req1_ready, (w == 1));
    @(posedge clk);
    m_win = w;
    if (rst) begin
      model_reset();
    end else if (w == 0) begin
      m_valid = 1; m_id = 0; m_last = 0;
      m_data  = ref_op(req0_op, req0_a, req0_b);
      m_cnt0  = (m_cnt0 + 1) % CNT_MOD;
    end else if (w == 1) begin
      m_valid = 1; m_id = 1; m_last = 1;
      m_data  = ref_op(req1_op, req1_a, req1_b);
      m_cnt1  = (m_cnt1 + 1) % CNT_MOD;
    end else if (rsp_ready) begin
      m_valid = 0;
    end
    @(negedge clk);
    chk("rsp_valid", rsp_valid, m_valid);
    chk("rsp_id",    rsp_id,    m_id);
    chk("rsp_data",  rsp_data,  m_data);
    chk("cnt0",      cnt0,      m_cnt0[CNT_WIDTH-1:0]);
    chk("cnt1",      cnt1,      m_cnt1[CNT_WIDTH-1:0]);
  endtask

  initial begin
    bit        p0, p1;
    bit [1:0]  op0, op1;
    bit [31:0] a0, b0, a1, b1;

    model_reset();
    m_win = -1;
    rst = 1; rsp_ready = 1;
    req0_valid = 1; req0_op = 2'd0; req0_a = 32'h1234_5678; req0_b = 32'hFFFF_0000;
    req1_valid = 1; req1_op = 2'd1; req1_a = 32'hDEAD_BEEF; req1_b = 32'h0000_FFFF;

    // Reset held two cycles with both ports requesting.
    cycle();
    cycle();
    chk("reset_rsp_data", rsp_data, 32'h0);
    rst = 0; req0_valid = 0; req1_valid = 0;

    // Single port AND.
    req0_valid = 1; req0_op = 2'd0; req0_a = 32'h00F0_10FF; req0_b = 32'hF0FF_FFFF;
    cycle();
    chk("and1_data", rsp_data, 32'h00F0_10FF);
    chk("and1_cnt0", cnt0, 4'd1);
    req0_a = 32'h07F0_10FF; req0_b = 32'h70FF_F000;
    cycle();
    chk("and2_data", rsp_data, 32'h00F0_1000);
    req0_valid = 0;
    cycle();

    // Contention: grants must alternate.
    req0_valid = 1; req0_op = 2'd2; req0_a = 32'h07F0_10FF; req0_b = 32'h70FF_F000;
    req1_valid = 1; req1_op = 2'd3; req1_a = 32'h00F0_10FF; req1_b = 32'hF0FF_FFFF;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("cont_data", rsp_data, (m_win == 0) ? 32'h770F_E0FF : 32'h0);
    end
    req0_valid = 0; req1_valid = 0;
    cycle();

    // Back-pressure: one OR accepted, then stalled with port 1 waiting.
    req0_valid = 1; req0_op = 2'd1; req0_a = 32'h00F0_10FF; req0_b = 32'h0;
    cycle();
    chk("bp_or_data", rsp_data, 32'h00F0_10FF);
    req0_valid = 0; rsp_ready = 0;
    req1_valid = 1; req1_op = 2'd2; req1_a = 32'hFFFF_0000; req1_b = 32'h0F0F_0F0F;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_hold_data", rsp_data, 32'h00F0_10FF);
    end
    rsp_ready = 1;
    cycle();
    chk("bp_release_data", rsp_data, 32'hF0F0_0F0F);
    req1_valid = 0;

    // Drain with nothing requesting.
    cycle();
    chk("drain_valid", rsp_valid, 1'b0);
    chk("drain_data",  rsp_data,  32'hF0F0_0F0F);

    // Counter wrap after 17 port-1 accepts, then reset with a result pending.
    rst = 1;
    cycle();
    rst = 0;
    req1_valid = 1; req1_op = 2'd1;
    for (int i = 0; i < 17; i++) begin
      req1_a = $urandom; req1_b = $urandom;
      cycle();
    end
    chk("wrap_cnt1", cnt1, 4'd1);
    req1_valid = 0; rsp_ready = 0;
    rst = 1;
    cycle();
    chk("midrst_valid", rsp_valid, 1'b0);
    chk("midrst_cnt1",  cnt1,      4'd0);
    rst = 0; rsp_ready = 1;

    // Randomised traffic; requesters hold their request until accepted.
    p0 = 0; p1 = 0;
    op0 = 0; op1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    for (int i = 0; i < 600; i++) begin
      if (!p0 && $urandom_range(0, 2) != 0) begin
        p0 = 1; op0 = 2'($urandom); a0 = $urandom; b0 = $urandom;
      end
      if (!p1 && $urandom_range(0, 2) != 0) begin
        p1 = 1; op1 = 2'($urandom); a1 = $urandom; b1 = $urandom;
      end
      req0_valid = p0; req0_op = op0; req0_a = a0; req0_b = b0;
      req1_valid = p1; req1_op = op1; req1_a = a1; req1_b = b1;
      rsp_ready  = ($urandom_range(0, 3) != 0);
      rst        = ($urandom_range(0, 79) == 0);
      cycle();
      if (m_win == 0) p0 = 0;
      if (m_win == 1) p1 = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1);
  end

endmodule
